iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits; legal values 8..64, power of two.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: InValid  input  1  operation request valid.
REQ-005 Port: InReady  output  1  block can accept a request this cycle.
REQ-006 Port: AIn, BIn  input  WIDTH each  operands.
REQ-007 Port: AccIn  input  WIDTH  accumulate operand (MLA only).
REQ-008 Port: ALUOperation  input  3  op select (REQ-013).
REQ-009 Port: InvertB, ALUCarry, ShCarryIn  input  1 each  invert B; carry-in to adder; shifter carry for logic ops.
REQ-010 Port: CVUpdate  input  2  carry/overflow update mode (REQ-015); PrevFlags  input  4  current NZCV.
REQ-011 Port: OutValid  output  1  Result/Flags valid; OutReady  input  1  consumer accepts result.
REQ-012 Port: Result  output  WIDTH  result; Flags  output  4  {N,Z,C,V}.

Function
REQ-013 Ops on A and CB (CB = InvertB ? ~BIn : BIn): 000 A&CB; 001 A^CB; 010 A+CB+ALUCarry; 011 A|CB; 100 CB; 101 CB with bit 0 cleared; 110 MUL (low WIDTH bits of AIn*BIn); 111 MLA (REQ-026).
REQ-014 Request accepted when InValid && InReady; AIn, BIn, AccIn, controls, PrevFlags, ShCarryIn captured at acceptance; later input changes ignored.
REQ-015 CVUpdate: 00 C=ShCarryIn, V=PrevFlags[0]; 01 C=Sum[WIDTH], V=(A^B)&(A^Sum) at MSB (subtract form); 10 C=Sum[WIDTH], V=~(A^B)&(A^Sum) at MSB (add form); 11 C,V = PrevFlags[1:0].
REQ-016 MUL/MLA: C,V always PrevFlags[1:0], CVUpdate ignored; N=Result[WIDTH-1], Z=(Result==0) for all ops.
REQ-017 FSM states IDLE, MULT, HOLD; reset state IDLE.
REQ-018 IDLE: InReady = !OutValid || OutReady; on accepted op 000-101 result and flags registered, OutValid=1 next cycle (latency 1), state stays IDLE.
REQ-019 IDLE: on accepted op 110/111 go MULT, load accumulator (zero, or AccIn per REQ-026), multiplicand=AIn, multiplier=BIn, counter=0; InReady=0 in MULT.
REQ-020 MULT: each cycle add multiplicand to accumulator if multiplier bit 0 set, shift multiplicand left 1, multiplier right 1, counter+1, all modulo 2^WIDTH.
REQ-021 MULT runs exactly WIDTH cycles regardless of operand values (B=0 included); then Result/Flags registered, OutValid=1, latency WIDTH+1 cycles from acceptance.
REQ-022 HOLD: entered if OutValid && !OutReady when MULT completes or result pending; Result/Flags/OutValid stable until OutReady; InReady=0 in MULT and HOLD.
REQ-023 OutValid clears the cycle after OutValid && OutReady unless a new single-cycle op accepted same cycle (back-to-back, one result per cycle).
REQ-024 InvertB and ALUCarry ignored by MUL/MLA.

Reset
REQ-025 reset asserted at any time (including mid-MULT or HOLD) immediately forces IDLE, OutValid=0, Result=0, Flags=0, accumulator/counter=0; InReady=1 while in IDLE after reset deasserts; in-flight op discarded.

Configuration
REQ-026 Macro ITER_ALU_MLA_EN: defined -> op 111 initialises accumulator to AccIn, Result = AIn*BIn+AccIn mod 2^WIDTH, same latency as MUL; undefined -> op 111 behaves exactly as 110, AccIn ignored.

Verification (WIDTH=32)
REQ-027 Accept ADD A=0x7FFFFFFF B=1 CVUpdate=10 -> next cycle Result=0x80000000 Flags=1001.
REQ-028 Accept SUB (op 010, InvertB=1, ALUCarry=1, CVUpdate=01) A=5 B=5 -> Result=0, Flags=0110.
REQ-029 Accept MUL A=0xFFFFFFFF B=0xFFFFFFFF PrevFlags=0011 -> OutValid exactly 33 cycles later, Result=1, Flags=0011; InReady=0 throughout MULT.
REQ-030 With ITER_ALU_MLA_EN, MLA A=3 B=4 AccIn=10 -> Result=22; without macro -> Result=12.
REQ-031 OutReady=0 held 5 cycles after MUL completes -> Result/Flags stable, InReady=0; OutReady=1 -> OutValid drops next cycle.
REQ-032 reset pulsed at MULT cycle 10 -> OutValid=0 immediately, no result produced; following AND 0xF0 & 0x3C -> Result=0x30.

Source files
------------

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/add ops plus a WIDTH-cycle shift-add multiplier.
// Optional macro ITER_ALU_MLA_EN makes op 111 a multiply-accumulate (AIn*BIn+AccIn).
module iter_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] AIn,
  input  logic [WIDTH-1:0] BIn,
  input  logic [WIDTH-1:0] AccIn,
  input  logic [2:0]       ALUOperation,
  input  logic             InvertB,
  input  logic             ALUCarry,
  input  logic             ShCarryIn,
  input  logic [1:0]       CVUpdate,
  input  logic [3:0]       PrevFlags,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       cv_q, cv_d;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_d;
  logic             valid_d;

  logic             accept;
  logic [WIDTH-1:0] cb, alu_res, acc_init, acc_step;
  logic [WIDTH:0]   sum;
  logic             c_flag, v_flag;

  assign InReady  = (state_q == IDLE) && (!OutValid || OutReady);
  assign accept   = InValid && InReady;
  assign cb       = InvertB ? ~BIn : BIn;
  assign sum      = {1'b0, AIn} + {1'b0, cb} + {{WIDTH{1'b0}}, ALUCarry};
  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

`ifdef ITER_ALU_MLA_EN
  assign acc_init = ALUOperation[0] ? AccIn : '0;
`else
  logic unused_acc_in;
  assign acc_init      = '0;
  assign unused_acc_in = ^AccIn;
`endif

  // N/Z of the previous flags are never forwarded; only C/V may pass through.
  logic unused_prev_nz;
  assign unused_prev_nz = ^PrevFlags[3:2];

  always_comb begin
    alu_res = '0;
    case (ALUOperation)
      3'b000:  alu_res = AIn & cb;
      3'b001:  alu_res = AIn ^ cb;
      3'b010:  alu_res = sum[WIDTH-1:0];
      3'b011:  alu_res = AIn | cb;
      3'b100:  alu_res = cb;
      3'b101:  alu_res = {cb[WIDTH-1:1], 1'b0};
      default: alu_res = '0;
    endcase
  end

  // Overflow is formed against the raw BIn, so the caller picks add or subtract form.
  always_comb begin
    c_flag = PrevFlags[1];
    v_flag = PrevFlags[0];
    case (CVUpdate)
      2'b00: begin
        c_flag = ShCarryIn;
        v_flag = PrevFlags[0];
      end
      2'b01: begin
        c_flag = sum[WIDTH];
        v_flag = (AIn[WIDTH-1] ^ BIn[WIDTH-1]) & (AIn[WIDTH-1] ^ sum[WIDTH-1]);
      end
      2'b10: begin
        c_flag = sum[WIDTH];
        v_flag = ~(AIn[WIDTH-1] ^ BIn[WIDTH-1]) & (AIn[WIDTH-1] ^ sum[WIDTH-1]);
      end
      default: begin
        c_flag = PrevFlags[1];
        v_flag = PrevFlags[0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    cv_d     = cv_q;
    result_d = Result;
    flags_d  = Flags;
    valid_d  = OutValid;
    case (state_q)
      IDLE: begin
        if (OutValid && OutReady) valid_d = 1'b0;
        if (accept) begin
          if (ALUOperation[2:1] == 2'b11) begin
            state_d  = MULT;
            acc_d    = acc_init;
            mcand_d  = AIn;
            mplier_d = BIn;
            cnt_d    = '0;
            cv_d     = PrevFlags[1:0];
            valid_d  = 1'b0;
          end else begin
            result_d = alu_res;
            flags_d  = {alu_res[WIDTH-1], alu_res == '0, c_flag, v_flag};
            valid_d  = 1'b1;
          end
        end else if (OutValid && !OutReady) begin
          state_d = HOLD;
        end
      end
      MULT: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // The final step's sum is registered straight into Result to keep latency at WIDTH+1.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = HOLD;
          result_d = acc_step;
          flags_d  = {acc_step[WIDTH-1], acc_step == '0, cv_q};
          valid_d  = 1'b1;
        end
      end
      HOLD: begin
        if (OutReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      cv_q     <= '0;
      Result   <= '0;
      Flags    <= '0;
      OutValid <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      cv_q     <= cv_d;
      Result   <= result_d;
      Flags    <= flags_d;
      OutValid <= valid_d;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=32) against an arithmetic reference model.
// Honours ITER_ALU_MLA_EN for the expected MLA behaviour.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid, InReady;
  logic [31:0] AIn, BIn, AccIn;
  logic [2:0]  ALUOperation;
  logic        InvertB, ALUCarry, ShCarryIn;
  logic [1:0]  CVUpdate;
  logic [3:0]  PrevFlags;
  logic        OutValid, OutReady;
  logic [31:0] Result;
  logic [3:0]  Flags;

  int passed = 0;
  int total  = 0;

  iter_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .AIn(AIn), .BIn(BIn), .AccIn(AccIn), .ALUOperation(ALUOperation),
    .InvertB(InvertB), .ALUCarry(ALUCarry), .ShCarryIn(ShCarryIn),
    .CVUpdate(CVUpdate), .PrevFlags(PrevFlags), .OutValid(OutValid),
    .OutReady(OutReady), .Result(Result), .Flags(Flags)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] op, input logic [31:0] a, b, acc,
                                input logic inv, carry, shc, input logic [1:0] cvu,
                                input logic [3:0] pf, output logic [31:0] res,
                                output logic [3:0] fl);
    logic [31:0] cb;
    logic [63:0] s, p;
    logic        c, v;
    cb = inv ? ~b : b;
    s  = 64'(a) + 64'(cb) + 64'(carry);
    p  = 64'(a) * 64'(b);
    case (op)
      3'd0: res = a & cb;
      3'd1: res = a ^ cb;
      3'd2: res = s[31:0];
      3'd3: res = a | cb;
      3'd4: res = cb;
      3'd5: res = cb & 32'hFFFF_FFFE;
      3'd6: res = p[31:0];
`ifdef ITER_ALU_MLA_EN
      default: res = p[31:0] + acc;
`else
      default: res = p[31:0];
`endif
    endcase
    c = pf[1];
    v = pf[0];
    if (op < 3'd6) begin
      case (cvu)
        2'b00: c = shc;
        2'b01: begin
          c = s[32];
          v = (a[31] ^ b[31]) & (a[31] ^ s[31]);
        end
        2'b10: begin
          c = s[32];
          v = ~(a[31] ^ b[31]) & (a[31] ^ s[31]);
        end
        default: ;
      endcase
    end
    fl = {res[31], res == 32'd0, c, v};
  endfunction

  task automatic set_inputs(input logic [2:0] op, input logic [31:0] a, b, acc,
                            input logic inv, carry, shc, input logic [1:0] cvu,
                            input logic [3:0] pf);
    ALUOperation = op; AIn = a; BIn = b; AccIn = acc;
    InvertB = inv; ALUCarry = carry; ShCarryIn = shc;
    CVUpdate = cvu; PrevFlags = pf;
  endtask

  // Starts a multiply at a negedge, scrambles inputs afterwards and waits (bounded) for OutValid.
  task automatic run_mul(input logic [2:0] op, input logic [31:0] a, b, acc,
                         input logic inv, carry, input logic [1:0] cvu,
                         input logic [3:0] pf, input logic rdy,
                         output int lat, output logic busy_ok);
    set_inputs(op, a, b, acc, inv, carry, 1'($urandom), cvu, pf);
    OutReady = rdy;
    InValid  = 1'b1;
    #1 busy_ok = (InReady === 1'b1);
    @(negedge clk);
    InValid = 1'b0;
    AIn = $urandom; BIn = $urandom; AccIn = $urandom;
    PrevFlags = 4'($urandom); ALUOperation = 3'($urandom);
    lat = 1;
    while (OutValid !== 1'b1 && lat < 40) begin
      if (InReady !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    set_inputs(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    repeat (2) @(negedge clk);
    total++;
    if ({OutValid, Result, Flags} !== 37'd0)
      $display("FAIL reset_outputs: OutValid=%b Result=%h Flags=%b, required 0/0/0", OutValid, Result, Flags);
    else passed++;
    reset = 1'b0;
    #1 total++;
    if (InReady !== 1'b1) $display("FAIL reset_inready: got %b, required 1", InReady);
    else passed++;
  endtask

  task automatic test_vectors();
    @(negedge clk);
    OutReady = 1'b1;
    set_inputs(3'd2, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0);
    InValid = 1'b1;
    @(negedge clk);
    total++;
    if ({OutValid, Result, Flags} !== {1'b1, 32'h8000_0000, 4'b1001})
      $display("FAIL add_overflow: valid=%b Result=%h Flags=%b, required 1/80000000/1001", OutValid, Result, Flags);
    else passed++;
    set_inputs(3'd2, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0, 2'b01, 4'd0);
    @(negedge clk);
    InValid = 1'b0;
    total++;
    if ({OutValid, Result, Flags} !== {1'b1, 32'd0, 4'b0110})
      $display("FAIL sub_equal: valid=%b Result=%h Flags=%b, required 1/00000000/0110", OutValid, Result, Flags);
    else passed++;
    @(negedge clk);
    total++;
    if (OutValid !== 1'b0) $display("FAIL valid_clear: got %b, required 0", OutValid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b, er;
    logic        inv, carry, shc, go;
    logic [1:0]  cvu;
    logic [3:0]  pf, ef;
    logic        ready_ok = 1'b1;
    OutReady = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
      if (i % 7 == 0) b = a;
      inv = 1'($urandom); carry = 1'($urandom); shc = 1'($urandom);
      cvu = 2'($urandom); pf = 4'($urandom); go = ($urandom_range(0, 3) != 0);
      set_inputs(op, a, b, $urandom, inv, carry, shc, cvu, pf);
      InValid = go;
      #1 if (InReady !== 1'b1) ready_ok = 1'b0;
      model(op, a, b, 32'd0, inv, carry, shc, cvu, pf, er, ef);
      @(negedge clk);
      total++;
      if (OutValid !== go) $display("FAIL b2b_valid[%0d]: got %b, required %b", i, OutValid, go);
      else passed++;
      if (go) begin
        total++;
        if ({Result, Flags} !== {er, ef})
          $display("FAIL b2b_result[%0d] op=%0d: got %h/%b, required %h/%b", i, op, Result, Flags, er, ef);
        else passed++;
      end
    end
    InValid = 1'b0;
    total++;
    if (ready_ok !== 1'b1) $display("FAIL b2b_inready: dropped while idle, required 1");
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int          lat;
    logic        busy_ok;
    logic [2:0]  op;
    logic [31:0] a, b, acc, er;
    logic [1:0]  cvu;
    logic [3:0]  pf, ef;
    run_mul(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 2'b10, 4'b0011, 1'b1, lat, busy_ok);
    total++;
    if (lat != 33) $display("FAIL mul_latency: got %0d, required 33", lat);
    else passed++;
    total++;
    if (busy_ok !== 1'b1) $display("FAIL mul_inready: accept/busy handshake wrong, required accept then 0");
    else passed++;
    total++;
    if ({Result, Flags} !== {32'd1, 4'b0011})
      $display("FAIL mul_max: got %h/%b, required 00000001/0011", Result, Flags);
    else passed++;
    @(negedge clk);
    total++;
    if (OutValid !== 1'b0) $display("FAIL mul_drain: OutValid=%b, required 0", OutValid);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      op = 3'($urandom_range(6, 7)); a = $urandom; b = (i == 0) ? 32'd0 : $urandom;
      acc = $urandom; cvu = 2'($urandom); pf = 4'($urandom);
      model(op, a, b, acc, 1'b0, 1'b0, 1'b0, cvu, pf, er, ef);
      run_mul(op, a, b, acc, 1'($urandom), 1'($urandom), cvu, pf, 1'b1, lat, busy_ok);
      total++;
      if (lat != 33 || busy_ok !== 1'b1 || {Result, Flags} !== {er, ef})
        $display("FAIL mul_rand[%0d]: lat=%0d busy_ok=%b got %h/%b, required 33/1/%h/%b",
                 i, lat, busy_ok, Result, Flags, er, ef);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_mla();
    int          lat;
    logic        busy_ok;
    logic [31:0] exp_r;
`ifdef ITER_ALU_MLA_EN
    exp_r = 32'd22;
`else
    exp_r = 32'd12;
`endif
    run_mul(3'd7, 32'd3, 32'd4, 32'd10, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, lat, busy_ok);
    total++;
    if (lat != 33 || Result !== exp_r)
      $display("FAIL mla_basic: lat=%0d Result=%h, required 33/%h", lat, Result, exp_r);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_hold();
    int          lat;
    logic        busy_ok;
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    a = $urandom; b = $urandom;
    model(3'd6, a, b, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1010, er, ef);
    run_mul(3'd6, a, b, 32'd0, 1'b0, 1'b0, 2'b00, 4'b1010, 1'b0, lat, busy_ok);
    total++;
    if (lat != 33 || {Result, Flags} !== {er, ef})
      $display("FAIL hold_first: lat=%0d got %h/%b, required 33/%h/%b", lat, Result, Flags, er, ef);
    else passed++;
    set_inputs(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({OutValid, InReady, Result, Flags} !== {1'b1, 1'b0, er, ef})
        $display("FAIL hold_stable[%0d]: valid=%b ready=%b got %h/%b, required 1/0/%h/%b",
                 i, OutValid, InReady, Result, Flags, er, ef);
      else passed++;
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    @(negedge clk);
    total++;
    if ({OutValid, InReady} !== 2'b01)
      $display("FAIL hold_release: valid=%b ready=%b, required 0/1", OutValid, InReady);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic        seen = 1'b0;
    logic [31:0] er;
    logic [3:0]  ef;
    set_inputs(3'd6, $urandom, $urandom, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0011);
    OutReady = 1'b1;
    InValid  = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1 total++;
    if ({OutValid, Result, Flags} !== 37'd0)
      $display("FAIL midreset_outputs: valid=%b Result=%h Flags=%b, required 0/0/0", OutValid, Result, Flags);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1 total++;
    if (InReady !== 1'b1) $display("FAIL midreset_inready: got %b, required 1", InReady);
    else passed++;
    repeat (40) begin
      @(negedge clk);
      if (OutValid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL midreset_discard: stale result appeared, required none");
    else passed++;
    set_inputs(3'd0, 32'hF0, 32'h3C, 32'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0001);
    model(3'd0, 32'hF0, 32'h3C, 32'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0001, er, ef);
    InValid = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    total++;
    if ({OutValid, Result, Flags} !== {1'b1, 32'h30, ef})
      $display("FAIL midreset_and: valid=%b got %h/%b, required 1/00000030/%b", OutValid, Result, Flags, ef);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mul();
    test_mla();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
